// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the Frankie multicycle CPU. It takes one memory
//   request per handshake from the control unit, resolves the address and
//   write-data sources, runs a single-port synchronous RAM access with a fixed
//   number of wait states, and returns the read word or a completion pulse.
//
// Parameters
//   DATA_W      data word width
//   ADDR_W      memory address width
//   WAIT_CYCLES wait cycles following the ACCESS cycle (1..15)
//   SP_STEP     byte offset added to sp for the SP-peek address source
//
// Ports
//   CLK, Reset          rising-edge clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   MemRead, MemWrite   operation select (exactly one must be set)
//   MemDst              address select: 000 pc, 001 imm, 011 mary, 100 sp,
//                       101 sp+SP_STEP
//   MemSrc              write-data select: 000 mary, 001 shelley, 010 ra
//   pc, imm, sp         address candidates
//   mary, shelley, ra   data candidates (mary doubles as an address)
//   mem_en, mem_we      RAM enable / write strobe
//   mem_addr, mem_wdata RAM address / write data (zero while mem_en is low)
//   mem_rdata           RAM read data, valid the cycle after an enabled cycle
//   rd_data             last captured read word
//   rd_valid, done, err single-cycle completion pulses
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 1,
  parameter int SP_STEP     = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        MemDst,
  input  logic [2:0]        MemSrc,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] imm,
  input  logic [ADDR_W-1:0] sp,
  input  logic [DATA_W-1:0] mary,
  input  logic [DATA_W-1:0] shelley,
  input  logic [DATA_W-1:0] ra,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_t;

  // Counter is loaded with WAIT_CYCLES-1 and runs down to zero.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t            state_reg;
  logic [3:0]        wait_cnt_reg;
  logic              is_read_reg;

  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] wdata_next;
  logic              dst_ok;
  logic              src_ok;
  logic              req_legal;

  // Source resolution for the request currently presented on the inputs.
  always_comb begin
    addr_next = '0;
    dst_ok    = 1'b1;
    case (MemDst)
      3'b000:  addr_next = pc;
      3'b001:  addr_next = imm;
      3'b011:  addr_next = ADDR_W'(mary);
      3'b100:  addr_next = sp;
      3'b101:  addr_next = sp + ADDR_W'(SP_STEP);  // wraps modulo 2^ADDR_W
      default: dst_ok    = 1'b0;
    endcase

    wdata_next = '0;
    src_ok     = 1'b1;
    case (MemSrc)
      3'b000:  wdata_next = mary;
      3'b001:  wdata_next = shelley;
      3'b010:  wdata_next = ra;
      default: src_ok     = 1'b0;
    endcase

    // The write-data source only matters for writes.
    req_legal = (MemRead ^ MemWrite) && dst_ok && (!MemWrite || src_ok);
  end

  // The registered RAM bus doubles as the latch for the in-flight request:
  // address and data are captured at accept and held until no longer needed.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
      is_read_reg  <= 1'b0;
      req_ready    <= 1'b1;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            req_ready   <= 1'b0;
            is_read_reg <= MemRead;
            if (req_legal) begin
              state_reg <= S_ACCESS;
              mem_en    <= 1'b1;
              mem_we    <= MemWrite;
              mem_addr  <= addr_next;
              mem_wdata <= MemWrite ? wdata_next : '0;
            end else begin
              // Illegal requests never touch the RAM.
              state_reg <= S_DONE;
              done      <= 1'b1;
              err       <= 1'b1;
            end
          end
        end

        S_ACCESS: begin
          state_reg    <= S_WAIT;
          wait_cnt_reg <= WAIT_LAST;
          mem_we       <= 1'b0;
          mem_wdata    <= '0;
          // Reads keep the RAM enabled on a stable address through WAIT.
          if (!is_read_reg) begin
            mem_en   <= 1'b0;
            mem_addr <= '0;
          end
        end

        S_WAIT: begin
          if (wait_cnt_reg == 4'd0) begin
            state_reg <= S_DONE;
            done      <= 1'b1;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            if (is_read_reg) begin
              rd_data  <= mem_rdata;
              rd_valid <= 1'b1;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end

        S_DONE: begin
          state_reg <= S_IDLE;
          req_ready <= 1'b1;
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//   Two responders share the request inputs: instance 0 with one wait state,
//   instance 1 with three. Each has its own req_valid and its own view of a
//   shared behavioural RAM. Expected results are queued when a request is
//   driven and compared when the responder reports done.
// ---------------------------------------------------------------------------
module tb_mem_responder;

  typedef struct {
    logic        err;
    logic        rd;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          acc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        MemRead, MemWrite;
  logic [2:0]  MemDst, MemSrc;
  logic [15:0] pc, imm, sp, mary, shelley, ra;

  logic        req_valid_v   [2];
  logic        req_ready_v   [2];
  logic        mem_en_v      [2];
  logic        mem_we_v      [2];
  logic [15:0] mem_addr_v    [2];
  logic [15:0] mem_wdata_v   [2];
  logic [15:0] mem_rdata_v   [2];
  logic [15:0] rd_data_v     [2];
  logic        rd_valid_v    [2];
  logic        done_v        [2];
  logic        err_v         [2];

  logic [15:0] ram [0:65535];
  exp_t        sb_q [2][$];
  int          en_cnt  [2];
  int          we_cnt  [2];
  logic [15:0] last_rd [2];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 CLK = ~CLK;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      mem_responder #(
        .DATA_W      (16),
        .ADDR_W      (16),
        .WAIT_CYCLES ((gi == 0) ? 1 : 3),
        .SP_STEP     (2)
      ) u_dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .req_valid (req_valid_v[gi]),
        .req_ready (req_ready_v[gi]),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemDst    (MemDst),
        .MemSrc    (MemSrc),
        .pc        (pc),
        .imm       (imm),
        .sp        (sp),
        .mary      (mary),
        .shelley   (shelley),
        .ra        (ra),
        .mem_en    (mem_en_v[gi]),
        .mem_we    (mem_we_v[gi]),
        .mem_addr  (mem_addr_v[gi]),
        .mem_wdata (mem_wdata_v[gi]),
        .mem_rdata (mem_rdata_v[gi]),
        .rd_data   (rd_data_v[gi]),
        .rd_valid  (rd_valid_v[gi]),
        .done      (done_v[gi]),
        .err       (err_v[gi])
      );
    end
  endgenerate

  function automatic int wc(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Behavioural RAM: preloaded during reset, registered read.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (Reset) begin
      for (int a = 0; a < 65536; a++)
        ram[a] <= (a == 16'h0040) ? 16'hBEEF : (16'(a) ^ 16'h5A3C);
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mem_en_v[i]) begin
          if (mem_we_v[i]) ram[mem_addr_v[i]] <= mem_wdata_v[i];
          mem_rdata_v[i] <= ram[mem_addr_v[i]];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model of one request, evaluated on the current inputs.
  function automatic exp_t model();
    exp_t e;
    logic dok, sok;
    e.addr  = '0;
    e.wdata = '0;
    dok = 1'b1;
    sok = 1'b1;
    case (MemDst)
      3'd0:    e.addr = pc;
      3'd1:    e.addr = imm;
      3'd3:    e.addr = mary;
      3'd4:    e.addr = sp;
      3'd5:    e.addr = sp + 16'd2;
      default: dok = 1'b0;
    endcase
    case (MemSrc)
      3'd0:    e.wdata = mary;
      3'd1:    e.wdata = shelley;
      3'd2:    e.wdata = ra;
      default: sok = 1'b0;
    endcase
    e.rd    = MemRead;
    e.err   = !((MemRead != MemWrite) && dok && (!MemWrite || sok));
    e.rdata = ram[e.addr];
    e.acc   = cyc;
    return e;
  endfunction

  task automatic mon(input int i);
    exp_t e;
    logic have;
    have = (sb_q[i].size() > 0);
    if (have) e = sb_q[i][0];

    if (!mem_en_v[i]) begin
      check("bus_idle", {15'd0, mem_we_v[i], mem_addr_v[i], mem_wdata_v[i]}, 48'd0);
    end else if (!have) begin
      check("stray_mem_en", 48'd1, 48'd0);
    end else begin
      en_cnt[i]++;
      check("mem_addr", 48'(mem_addr_v[i]), 48'(e.addr));
      if (mem_we_v[i]) begin
        we_cnt[i]++;
        check("mem_wdata", 48'(mem_wdata_v[i]), 48'(e.wdata));
      end
    end

    if (done_v[i]) begin
      if (!have) begin
        check("stray_done", 48'd1, 48'd0);
      end else begin
        void'(sb_q[i].pop_front());
        if (e.rd && !e.err) last_rd[i] = e.rdata;
        check("err", 48'(err_v[i]), 48'(e.err));
        check("rd_valid", 48'(rd_valid_v[i]), 48'(e.rd && !e.err));
        check("rd_data", 48'(rd_data_v[i]), 48'(last_rd[i]));
        check("latency", 48'(cyc - e.acc), e.err ? 48'd1 : 48'(2 + wc(i)));
        check("en_cycles", 48'(en_cnt[i]), e.err ? 48'd0 : (e.rd ? 48'(1 + wc(i)) : 48'd1));
        check("we_cycles", 48'(we_cnt[i]), (!e.err && !e.rd) ? 48'd1 : 48'd0);
        $display("txn inst=%0d rd=%0d err=%0d addr=%h wdata=%h rd_data=%h",
                 i, e.rd, e.err, e.addr, e.wdata, rd_data_v[i]);
      end
      en_cnt[i] = 0;
      we_cnt[i] = 0;
    end else begin
      check("no_pulse", {46'd0, rd_valid_v[i], err_v[i]}, 48'd0);
    end
  endtask

  // Monitor: a reset drops any in-flight request and clears rd_data.
  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        sb_q[i].delete();
        en_cnt[i]  = 0;
        we_cnt[i]  = 0;
        last_rd[i] = 16'h0000;
      end else begin
        mon(i);
      end
    end
  end

  task automatic set_req(input logic rd, input logic wr, input logic [2:0] dst, input logic [2:0] src);
    MemRead  = rd;
    MemWrite = wr;
    MemDst   = dst;
    MemSrc   = src;
  endtask

  task automatic scramble();
    pc = 16'($urandom); imm = 16'($urandom); sp = 16'($urandom);
    mary = 16'($urandom); shelley = 16'($urandom); ra = 16'($urandom);
    set_req(1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom));
  endtask

  // Counts negedges with req_ready low; bounded.
  task automatic wait_ready(input int i, output int lows);
    lows = 0;
    while (!req_ready_v[i] && lows < 64) begin
      lows++;
      @(negedge CLK);
    end
    if (lows == 64) check("ready_timeout", 48'd0, 48'd1);
  endtask

  // Issue the request on the inputs; it is accepted on the next rising edge.
  // Inputs are scrambled right after accept to prove they were latched.
  task automatic run_req(input int i);
    int   lows;
    exp_t e;
    req_valid_v[i] = 1'b1;
    wait_ready(i, lows);
    e = model();
    sb_q[i].push_back(e);
    @(negedge CLK);
    req_valid_v[i] = 1'b0;
    scramble();
    wait_ready(i, lows);
    check("ready_low", 48'(lows), e.err ? 48'd1 : 48'(2 + wc(i)));
  endtask

  initial begin
    int lows;
    Reset = 1'b1;
    req_valid_v[0] = 1'b0;
    req_valid_v[1] = 1'b0;
    pc = '0; imm = '0; sp = '0; mary = '0; shelley = '0; ra = '0;
    set_req(1'b0, 1'b0, 3'd0, 3'd0);
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", 48'(req_ready_v[i]), 48'd1);
      check("rst_ctrl", {43'd0, mem_en_v[i], mem_we_v[i], rd_valid_v[i], done_v[i], err_v[i]}, 48'd0);
      check("rst_bus", {16'd0, mem_addr_v[i], mem_wdata_v[i]}, 48'd0);
      check("rst_rd_data", 48'(rd_data_v[i]), 48'd0);
    end
    Reset = 1'b0;
    @(negedge CLK);

    // Read from pc=0x0040 (holds BEEF).
    set_req(1'b1, 1'b0, 3'd0, 3'd0); pc = 16'h0040;
    run_req(0);
    // Write ra to sp; rd_data must stay BEEF.
    set_req(1'b0, 1'b1, 3'd4, 3'd2); sp = 16'h0100; ra = 16'h1234;
    run_req(0);
    // Read back through sp.
    set_req(1'b1, 1'b0, 3'd4, 3'd0); sp = 16'h0100;
    run_req(0);
    // Peek wraps: 0xFFFF + 2 = 0x0001.
    set_req(1'b1, 1'b0, 3'd5, 3'd0); sp = 16'hFFFF;
    run_req(0);
    // Illegal requests.
    set_req(1'b1, 1'b1, 3'd0, 3'd0); run_req(0);
    set_req(1'b1, 1'b0, 3'd2, 3'd0); run_req(0);
    set_req(1'b0, 1'b0, 3'd0, 3'd0); run_req(0);
    set_req(1'b0, 1'b1, 3'd0, 3'd3); run_req(0);
    // Other legal sources.
    set_req(1'b0, 1'b1, 3'd1, 3'd1); imm = 16'h0222; shelley = 16'h7E57; run_req(0);
    set_req(1'b1, 1'b0, 3'd3, 3'd0); mary = 16'h0222; run_req(0);

    // Back-to-back on the three-wait-state instance with req_valid held.
    set_req(1'b1, 1'b0, 3'd1, 3'd0); imm = 16'h0200;
    req_valid_v[1] = 1'b1;
    wait_ready(1, lows);
    sb_q[1].push_back(model());
    @(negedge CLK);
    set_req(1'b0, 1'b1, 3'd3, 3'd1); mary = 16'h0300; shelley = 16'h5A5A;
    wait_ready(1, lows);
    check("b2b_ready_low_1", 48'(lows), 48'd5);
    sb_q[1].push_back(model());
    @(negedge CLK);
    req_valid_v[1] = 1'b0;
    wait_ready(1, lows);
    check("b2b_ready_low_2", 48'(lows), 48'd5);

    // Random mix on both instances.
    for (int k = 0; k < 24; k++) begin
      scramble();
      run_req(k % 2);
    end
    repeat (2) @(negedge CLK);
    check("sb_empty_0", 48'(sb_q[0].size()), 48'd0);
    check("sb_empty_1", 48'(sb_q[1].size()), 48'd0);

    // Reset during WAIT of a write.
    set_req(1'b0, 1'b1, 3'd0, 3'd0); pc = 16'h0500; mary = 16'hCAFE;
    req_valid_v[1] = 1'b1;
    wait_ready(1, lows);
    sb_q[1].push_back(model());
    @(negedge CLK);               // ACCESS: the single write strobe
    req_valid_v[1] = 1'b0;
    @(negedge CLK);               // first WAIT cycle
    Reset = 1'b1;
    @(negedge CLK);
    check("mid_rst_ready", 48'(req_ready_v[1]), 48'd1);
    check("mid_rst_ctrl", {43'd0, mem_en_v[1], mem_we_v[1], rd_valid_v[1], done_v[1], err_v[1]}, 48'd0);
    check("mid_rst_bus", {16'd0, mem_addr_v[1], mem_wdata_v[1]}, 48'd0);
    check("mid_rst_rd_data", 48'(rd_data_v[1]), 48'd0);
    Reset = 1'b0;
    repeat (8) @(negedge CLK);    // monitor flags any stray done or mem_en
    // Recovery read after reset.
    set_req(1'b1, 1'b0, 3'd0, 3'd0); pc = 16'h0040;
    run_req(1);
    repeat (2) @(negedge CLK);
    check("sb_empty_end", 48'(sb_q[1].size()), 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
